// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C init sequencer and its gap timer.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_POLL_WAIT = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  typedef enum logic {
    PH_WR = 1'b0,
    PH_RD = 1'b1
  } phase_t;

  localparam logic [7:0] DEV_WR_DEFAULT = 8'hA6;
  localparam logic [7:0] DEV_RD_DEFAULT = 8'hA7;

endpackage

// File: rtl/i2c_gap_timer.sv
// Loadable down-counter that spaces transactions for a master with no done flag.
module i2c_gap_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load on request, otherwise count down and rest at zero.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/i2c_init_seq.sv
// Replays a fixed table of I2C writes, then issues reads and presents each result.
// Build option: define I2C_INIT_SEQ_POLL_EN to keep reading forever with a
// POLL_CYCLES pause between reads; without it a single read is done.
module i2c_init_seq
  import i2c_pkg::*;
#(
  parameter int                    INIT_LEN    = 4,
  parameter logic [INIT_LEN*8-1:0] INIT_ROM    = {8'h2D, 8'h08, 8'h31, 8'h0B},
  parameter logic [7:0]            DEV_WR      = DEV_WR_DEFAULT,
  parameter logic [7:0]            DEV_RD      = DEV_RD_DEFAULT,
  parameter logic [7:0]            RD_REG      = 8'h32,
  parameter int                    GAP_CYCLES  = 250000,
  parameter int                    POLL_CYCLES = 500000,
  parameter int                    CNT_W       = 20
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        start,
  output logic        i2c_en,
  output logic [7:0]  i2c_addr,
  output logic [7:0]  i2c_data,
  input  logic [15:0] i2c_rdata,
  output logic [15:0] sample,
  output logic        sample_vld,
  output logic        init_done,
  output logic        busy
);

  localparam int MAX_CNT = (GAP_CYCLES > POLL_CYCLES) ? GAP_CYCLES : POLL_CYCLES;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX = 4'(INIT_LEN - 1);

  if (CNT_W < $clog2(MAX_CNT)) begin : g_cnt_w_check
    $error("CNT_W is too narrow for GAP_CYCLES/POLL_CYCLES");
  end

  state_t           state, next_state;
  phase_t           phase, nxt_phase;
  logic [3:0]       idx, nxt_idx;
  logic             go_issue, go_capture, set_init;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  // Entry 0 sits in the top byte of INIT_ROM.
  function automatic logic [7:0] rom_entry(input logic [3:0] i);
    rom_entry = 8'h00;
    for (int k = 0; k < INIT_LEN; k++) begin
      if (i == 4'(k)) rom_entry = INIT_ROM[(INIT_LEN-1-k)*8 +: 8];
    end
  endfunction

  i2c_gap_timer #(.CNT_W(CNT_W)) u_gap_timer (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state decode plus the one-cycle controls for the datapath and timer.
  always_comb begin
    next_state = state;
    nxt_idx    = idx;
    nxt_phase  = phase;
    go_issue   = 1'b0;
    go_capture = 1'b0;
    set_init   = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = GAP_LOAD;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_ISSUE;
          go_issue   = 1'b1;
          nxt_idx    = 4'd0;
          nxt_phase  = PH_WR;
        end
      end
      ST_ISSUE: begin
        next_state = ST_WAIT;
        tmr_load   = 1'b1;
      end
      ST_WAIT: begin
        if (tmr_zero) begin
          if (phase == PH_RD) begin
            next_state = ST_CAPTURE;
            go_capture = 1'b1;
          end else if (idx == LAST_IDX) begin
            next_state = ST_ISSUE;
            go_issue   = 1'b1;
            set_init   = 1'b1;
            nxt_phase  = PH_RD;
          end else begin
            next_state = ST_ISSUE;
            go_issue   = 1'b1;
            nxt_idx    = idx + 4'd1;
          end
        end
      end
`ifdef I2C_INIT_SEQ_POLL_EN
      ST_CAPTURE: begin
        next_state = ST_POLL_WAIT;
        tmr_load   = 1'b1;
        tmr_val    = CNT_W'(POLL_CYCLES - 1);
      end
      ST_POLL_WAIT: begin
        if (tmr_zero) begin
          next_state = ST_ISSUE;
          go_issue   = 1'b1;
        end
      end
`else
      ST_CAPTURE: begin
        next_state = ST_DONE;
      end
`endif
      ST_DONE: begin
        next_state = ST_DONE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Registered table position, bus bytes, captured sample and sticky init flag.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 4'd0;
      phase      <= PH_WR;
      i2c_addr   <= 8'h00;
      i2c_data   <= 8'h00;
      sample     <= 16'h0000;
      sample_vld <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      sample_vld <= go_capture;
      if (go_capture) sample <= i2c_rdata;
      if (set_init) init_done <= 1'b1;
      if (go_issue) begin
        idx   <= nxt_idx;
        phase <= nxt_phase;
        if (nxt_phase == PH_RD) begin
          i2c_addr <= DEV_RD;
          i2c_data <= RD_REG;
        end else begin
          i2c_addr <= DEV_WR;
          i2c_data <= rom_entry(nxt_idx);
        end
      end
    end
  end

  assign i2c_en = (state == ST_ISSUE);
  assign busy   = (state != ST_IDLE) && (state != ST_DONE);

endmodule
